// File: rtl/pipelined_addsub.sv
// Add/subtract with a Kogge-Stone carry network spread over STAGES ready/valid register stages.
// Define ADDSUB_SAT_EN to clamp unsigned overflow/borrow of the sum output.
module pipelined_addsub #(
  parameter int WIDTH  = 24,
  parameter int STAGES = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             op,
  input  logic             cin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf
);

  localparam int LEVELS = $clog2(WIDTH);

  function automatic logic [WIDTH-1:0] ks_g(input logic [WIDTH-1:0] g_in,
                                            input logic [WIDTH-1:0] p_in,
                                            input int lo, input int hi);
    logic [WIDTH-1:0] g, p, ng, np;
    int d;
    g = g_in;
    p = p_in;
    for (int l = 0; l < LEVELS; l++) begin
      if (l >= lo && l < hi) begin
        d  = 1 << l;
        ng = g;
        np = p;
        for (int i = d; i < WIDTH; i++) begin
          ng[i] = g[i] | (p[i] & g[i-d]);
          np[i] = p[i] & p[i-d];
        end
        g = ng;
        p = np;
      end
    end
    return g;
  endfunction

  function automatic logic [WIDTH-1:0] ks_p(input logic [WIDTH-1:0] p_in,
                                            input int lo, input int hi);
    logic [WIDTH-1:0] p, np;
    int d;
    p = p_in;
    for (int l = 0; l < LEVELS; l++) begin
      if (l >= lo && l < hi) begin
        d  = 1 << l;
        np = p;
        for (int i = d; i < WIDTH; i++) np[i] = p[i] & p[i-d];
        p = np;
      end
    end
    return p;
  endfunction

  logic [STAGES-1:0] vld;
  logic [STAGES-1:0] adv;
  logic              accept;

  always_comb begin
    logic nxt;
    nxt = out_ready;
    adv = '0;
    for (int k = STAGES - 1; k >= 0; k--) begin
      nxt    = !vld[k] || nxt;
      adv[k] = nxt;
    end
  end

  assign in_ready = adv[0] && !reset;
  assign accept   = in_valid && in_ready;

  // Carry-in is folded into bit 0's generate so the prefix tree yields true carries.
  logic [WIDTH-1:0] b_eff, x0, g0;
  logic             c0;

  assign b_eff = op ? ~b : b;
  assign c0    = op ? ~cin : cin;
  assign x0    = a ^ b_eff;

  always_comb begin
    g0    = a & b_eff;
    g0[0] = g0[0] | (x0[0] & c0);
  end

  for (genvar k = 0; k < STAGES; k++) begin : g_stage
    localparam int LO = k * LEVELS / STAGES;
    localparam int HI = (k + 1) * LEVELS / STAGES;

    logic [WIDTH-1:0] g_in, p_in, x_in;
    logic             c0_in, op_in, sa_in, v_in;
    logic             v_q;

    if (k == 0) begin : g_src
      assign g_in  = g0;
      assign p_in  = x0;
      assign x_in  = x0;
      assign c0_in = c0;
      assign op_in = op;
      assign sa_in = a[WIDTH-1];
      assign v_in  = accept;
    end else begin : g_src
      assign g_in  = g_stage[k-1].g_mid.g_q;
      assign p_in  = g_stage[k-1].g_mid.p_q;
      assign x_in  = g_stage[k-1].g_mid.x_q;
      assign c0_in = g_stage[k-1].g_mid.c0_q;
      assign op_in = g_stage[k-1].g_mid.op_q;
      assign sa_in = g_stage[k-1].g_mid.sa_q;
      assign v_in  = g_stage[k-1].v_q;
    end

    always_ff @(posedge clk or posedge reset) begin
      if (reset)       v_q <= 1'b0;
      else if (adv[k]) v_q <= v_in;
    end

    assign vld[k] = v_q;

    if (k < STAGES - 1) begin : g_mid
      logic [WIDTH-1:0] g_d, p_d, g_q, p_q, x_q;
      logic             c0_q, op_q, sa_q;

      assign g_d = ks_g(g_in, p_in, LO, HI);
      assign p_d = ks_p(p_in, LO, HI);

      always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
          g_q  <= '0;
          p_q  <= '0;
          x_q  <= '0;
          c0_q <= 1'b0;
          op_q <= 1'b0;
          sa_q <= 1'b0;
        end else if (adv[k] && v_in) begin
          g_q  <= g_d;
          p_q  <= p_d;
          x_q  <= x_in;
          c0_q <= c0_in;
          op_q <= op_in;
          sa_q <= sa_in;
        end
      end
    end else begin : g_last
      logic [WIDTH-1:0] g_fin, sum_raw, sum_d, sum_q;
      logic             co_raw, cout_d, ovf_d, cout_q, ovf_q;

      assign g_fin   = ks_g(g_in, p_in, LO, HI);
      assign sum_raw = x_in ^ {g_fin[WIDTH-2:0], c0_in};
      assign co_raw  = g_fin[WIDTH-1];
      assign cout_d  = op_in ? ~co_raw : co_raw;
      assign ovf_d   = ~x_in[WIDTH-1] & (sum_raw[WIDTH-1] ^ sa_in);
`ifdef ADDSUB_SAT_EN
      assign sum_d   = cout_d ? (op_in ? '0 : '1) : sum_raw;
`else
      assign sum_d   = sum_raw;
`endif

      always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
          sum_q  <= '0;
          cout_q <= 1'b0;
          ovf_q  <= 1'b0;
        end else if (adv[k] && v_in) begin
          sum_q  <= sum_d;
          cout_q <= cout_d;
          ovf_q  <= ovf_d;
        end
      end
    end
  end

  assign out_valid = vld[STAGES-1];
  assign sum       = g_stage[STAGES-1].g_last.sum_q;
  assign cout      = g_stage[STAGES-1].g_last.cout_q;
  assign ovf       = g_stage[STAGES-1].g_last.ovf_q;

endmodule

// File: tb/tb_pipelined_addsub.sv
// Randomized bench for pipelined_addsub: arithmetic reference model plus directed corner cases.
module tb_pipelined_addsub;
  localparam int WIDTH  = 24;
  localparam int STAGES = 2;
`ifdef ADDSUB_SAT_EN
  localparam bit SAT = 1'b1;
`else
  localparam bit SAT = 1'b0;
`endif

  logic             clk = 1'b0;
  logic             reset, in_valid, in_ready, op, cin, out_valid, out_ready, cout, ovf;
  logic [WIDTH-1:0] a, b, sum;

  always #5 clk = ~clk;

  pipelined_addsub #(.WIDTH(WIDTH), .STAGES(STAGES)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .op(op), .cin(cin),
    .out_valid(out_valid), .out_ready(out_ready),
    .sum(sum), .cout(cout), .ovf(ovf)
  );

  typedef struct packed {
    logic [WIDTH-1:0] sum;
    logic             cout;
    logic             ovf;
  } res_t;

  res_t exp_q[$];
  res_t r_mon, held;
  int   n_chk = 0, n_fail = 0, in_cnt = 0, out_cnt = 0;
  logic mon_en = 1'b0, stalled = 1'b0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic res_t model(input logic [WIDTH-1:0] av, input logic [WIDTH-1:0] bv,
                                 input logic opv, input logic cinv);
    res_t   r;
    longint ua, ub, sa, sb, c, full, rs, maxs, mins;
    ua   = longint'(av);
    ub   = longint'(bv);
    sa   = longint'($signed(av));
    sb   = longint'($signed(bv));
    c    = longint'(cinv);
    maxs = (64'sd1 <<< (WIDTH - 1)) - 1;
    mins = -(64'sd1 <<< (WIDTH - 1));
    if (!opv) begin
      full   = ua + ub + c;
      r.cout = (full >= (64'sd1 <<< WIDTH));
      rs     = sa + sb + c;
    end else begin
      full   = ua - ub - c;
      r.cout = (ua < ub + c);
      rs     = sa - sb - c;
    end
    r.sum = full[WIDTH-1:0];
    r.ovf = (rs > maxs) || (rs < mins);
    if (SAT && r.cout) r.sum = opv ? '0 : '1;
    return r;
  endfunction

  always @(negedge clk) begin
    if (reset) begin
      stalled = 1'b0;
    end else if (mon_en) begin
      if (stalled && out_valid) begin
        check("hold_sum", sum, held.sum);
        check("hold_cout", cout, held.cout);
        check("hold_ovf", ovf, held.ovf);
      end
      if (out_valid && out_ready) begin
        check("out_has_pending", exp_q.size() > 0, 1);
        if (exp_q.size() > 0) begin
          r_mon = exp_q.pop_front();
          check("stream_sum", sum, r_mon.sum);
          check("stream_cout", cout, r_mon.cout);
          check("stream_ovf", ovf, r_mon.ovf);
        end
        out_cnt++;
      end
      if (in_valid && in_ready) begin
        exp_q.push_back(model(a, b, op, cin));
        in_cnt++;
      end
      stalled = out_valid && !out_ready;
      held    = '{sum, cout, ovf};
    end
  end

  task automatic rand_beat();
    logic [WIDTH-1:0] corner [4];
    corner[0] = '0; corner[1] = '1; corner[2] = {1'b0, {(WIDTH-1){1'b1}}}; corner[3] = {1'b1, {(WIDTH-1){1'b0}}};
    a   = ($urandom_range(0, 7) == 0) ? corner[$urandom_range(0, 3)] : WIDTH'($urandom);
    b   = ($urandom_range(0, 7) == 0) ? corner[$urandom_range(0, 3)] : WIDTH'($urandom);
    op  = 1'($urandom);
    cin = 1'($urandom);
  endtask

  task automatic wait_drained(input int budget);
    for (int i = 0; i < budget && exp_q.size() != 0; i++) @(posedge clk);
    #1;
    check("drain_pending", exp_q.size(), 0);
  endtask

  task automatic directed(input string tag, input logic [WIDTH-1:0] av, input logic [WIDTH-1:0] bv,
                          input logic opv, input logic cinv,
                          input logic [WIDTH-1:0] es, input logic ec, input logic eo);
    @(posedge clk); #1;
    a = av; b = bv; op = opv; cin = cinv; in_valid = 1'b1; out_ready = 1'b1;
    #1 check({tag, "_in_ready"}, in_ready, 1);
    @(posedge clk); #1;
    in_valid = 1'b0;
    for (int i = 1; i < STAGES; i++) begin
      check({tag, "_early"}, out_valid, 0);
      @(posedge clk); #1;
    end
    check({tag, "_valid"}, out_valid, 1);
    check({tag, "_sum"}, sum, es);
    check({tag, "_cout"}, cout, ec);
    check({tag, "_ovf"}, ovf, eo);
  endtask

  initial begin
    int c0;
    reset = 1'b1; in_valid = 1'b0; out_ready = 1'b0; a = '0; b = '0; op = 1'b0; cin = 1'b0;
    repeat (3) @(posedge clk);
    #1 out_ready = 1'b1;
    #1;
    check("rst_out_valid", out_valid, 0);
    check("rst_sum", sum, 0);
    check("rst_cout", cout, 0);
    check("rst_ovf", ovf, 0);
    check("rst_in_ready", in_ready, 0);
    @(posedge clk); #1 reset = 1'b0;
    #1 check("post_rel_in_ready", in_ready, 1);
    mon_en = 1'b1;

    directed("add_wrap", 24'hFFFFFF, 24'h000001, 1'b0, 1'b0, SAT ? 24'hFFFFFF : 24'h000000, 1'b1, 1'b0);
    directed("sub_borrow", 24'h000005, 24'h000007, 1'b1, 1'b0, SAT ? 24'h000000 : 24'hFFFFFE, 1'b1, 1'b0);
    directed("add_ovf", 24'h7FFFFF, 24'h000001, 1'b0, 1'b0, 24'h800000, 1'b0, 1'b1);
    directed("sub_ovf", 24'h800000, 24'h000001, 1'b1, 1'b0, 24'h7FFFFF, 1'b0, 1'b1);
    directed("add_cin", 24'h123456, 24'h111111, 1'b0, 1'b1, 24'h234568, 1'b0, 1'b0);

    // Backpressure: capacity is STAGES beats
    wait_drained(20);
    c0 = out_cnt;
    @(posedge clk); #1 out_ready = 1'b0; in_valid = 1'b1; rand_beat();
    #1 check("bp_accept0", in_ready, 1);
    @(posedge clk); #1 rand_beat();
    #1 check("bp_accept1", in_ready, 1);
    @(posedge clk); #1 rand_beat();
    #1 check("bp_full", in_ready, 0);
    repeat (3) begin
      @(posedge clk); #1;
      check("bp_full_hold", in_ready, 0);
      check("bp_out_valid", out_valid, 1);
    end
    out_ready = 1'b1;
    @(posedge clk); #1 in_valid = 1'b0;
    wait_drained(20);
    check("bp_count", out_cnt - c0, 3);

    // Full throughput
    c0 = out_cnt;
    in_valid = 1'b1; out_ready = 1'b1;
    for (int i = 0; i < 50; i++) begin
      @(posedge clk); #1 rand_beat();
      #1;
      check("tput_in_ready", in_ready, 1);
      if (i >= STAGES) check("tput_out_valid", out_valid, 1);
    end
    @(posedge clk); #1 in_valid = 1'b0;
    wait_drained(20);
    check("tput_count", out_cnt - c0, 51);

    // Random stream with random stalls
    c0 = in_cnt;
    for (int cyc = 0; cyc < 30000; cyc++) begin
      @(posedge clk); #1;
      if (in_cnt - c0 >= 1000) break;
      in_valid  = ($urandom_range(0, 3) != 0);
      out_ready = ($urandom_range(0, 3) != 0);
      rand_beat();
    end
    in_valid = 1'b0; out_ready = 1'b1;
    check("rand_accepted", in_cnt - c0, 1000);
    wait_drained(50);

    // Reset with beats in flight
    @(posedge clk); #1 in_valid = 1'b1; out_ready = 1'b0; rand_beat();
    @(posedge clk); #1 rand_beat();
    @(posedge clk); #1 in_valid = 1'b0;
    check("flight_full", out_valid, 1);
    reset = 1'b1;
    #1;
    exp_q.delete();
    check("flight_rst_valid", out_valid, 0);
    check("flight_rst_sum", sum, 0);
    check("flight_rst_in_ready", in_ready, 0);
    repeat (2) @(posedge clk);
    #1 reset = 1'b0; out_ready = 1'b1;
    #1 check("flight_rel_in_ready", in_ready, 1);
    repeat (3) begin
      @(posedge clk); #1;
      check("flight_no_stale", out_valid, 0);
    end
    directed("post_rst", 24'hABCDEF, 24'h012345, 1'b1, 1'b1, 24'hAAAAA9, 1'b0, 1'b0);
    wait_drained(20);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end
endmodule

// File: doc/pipelined_addsub.md
PIPELINED_ADDSUB -- requirements
Module: pipelined_addsub

Interface
REQ-001 Parameter WIDTH, default 24: operand and result width in bits, legal range 4..64.
REQ-002 Parameter STAGES, default 2: number of register stages from input to output, legal range 1..4.
REQ-003 Port clk, input, 1: single clock; all state SHALL update on its rising edge.
REQ-004 Port reset, input, 1: asynchronous, active-high reset.
REQ-005 Port in_valid, input, 1: an operand beat is presented.
REQ-006 Port in_ready, output, 1: the block accepts the beat this cycle.
REQ-007 Port a, input, WIDTH: first operand.
REQ-008 Port b, input, WIDTH: second operand.
REQ-009 Port op, input, 1: 0 selects add, 1 selects subtract.
REQ-010 Port cin, input, 1: carry-in for add, borrow-in for subtract.
REQ-011 Port out_valid, output, 1: a result is presented.
REQ-012 Port out_ready, input, 1: the consumer accepts the result this cycle.
REQ-013 Port sum, output, WIDTH: result.
REQ-014 Port cout, output, 1: carry-out for add, borrow-out for subtract.
REQ-015 Port ovf, output, 1: two's-complement signed overflow of the unsaturated result.

Function
REQ-016 Add SHALL compute {cout,sum} = a + b + cin.
REQ-017 Subtract SHALL compute a + ~b + !cin; sum is the low WIDTH bits, and cout SHALL be the inverse of the internal carry (1 = borrow).
REQ-018 Carries SHALL come from a Kogge-Stone parallel-prefix network of ceil(log2(WIDTH)) levels, with levels split as evenly as possible across the STAGES register boundaries.
REQ-019 ovf SHALL be 1 when a and the effective b operand have equal sign bits and the unsaturated sum's sign differs from them.
REQ-020 A beat SHALL transfer in on a cycle when in_valid && in_ready, and out on a cycle when out_valid && out_ready.
REQ-021 Stage k SHALL advance when it is empty or stage k+1 advances; the last stage advances when it is empty or out_ready is 1.
REQ-022 in_ready SHALL equal the first stage's advance condition; it SHALL be combinational from out_ready and stage valid bits only, never from in_valid.
REQ-023 With no stalls, latency SHALL be exactly STAGES cycles and throughput one result per cycle.
REQ-024 While out_valid=1 and out_ready=0, sum, cout and ovf SHALL hold stable.
REQ-025 Capacity SHALL be STAGES beats; when all stages are full and out_ready=0, in_ready SHALL be 0.
REQ-026 Results SHALL leave in acceptance order, with none dropped or duplicated.
REQ-027 Simultaneous accept and emit on a full pipeline SHALL be lossless, with no bubble inserted.
REQ-028 op and cin SHALL travel with their beat; mixed add/subtract streams SHALL be legal back-to-back.

Reset
REQ-029 While reset=1, all stage valid bits, out_valid, sum, cout and ovf SHALL be 0.
REQ-030 While reset=1, in_ready SHALL be 0; in the first cycle after release, in_ready SHALL be 1.
REQ-031 Beats in flight when reset asserts SHALL be discarded and never emitted.

Configuration
REQ-032 Macro ADDSUB_SAT_EN, when defined, SHALL enable unsigned saturation: add with cout=1 gives sum all-ones, subtract with borrow=1 gives sum 0; cout and ovf still report the raw result.
REQ-033 Without ADDSUB_SAT_EN, sum SHALL be the wrapped modulo-2^WIDTH result, and no saturation logic SHALL be present.

Verification (WIDTH=24, STAGES=2)
REQ-034 Add a=0xFFFFFF, b=0x000001, cin=0 -> two cycles later sum=0x000000, cout=1, ovf=0; with ADDSUB_SAT_EN, sum=0xFFFFFF.
REQ-035 Subtract a=0x000005, b=0x000007, cin=0 -> sum=0xFFFFFE, cout=1; with ADDSUB_SAT_EN, sum=0x000000, cout=1.
REQ-036 Add a=0x7FFFFF, b=0x000001 -> sum=0x800000, ovf=1, cout=0; subtract a=0x800000, b=0x000001 -> sum=0x7FFFFF, ovf=1, cout=0.
REQ-037 Hold out_ready=0 and offer 3 beats -> 2 are accepted, in_ready=0 on the 3rd; outputs are stable. Then out_ready=1 -> all 3 emerge in order.
REQ-038 Stream 1000 random beats with random in_valid and out_ready -> every result matches the reference model, in order, with no loss; with both held at 1, exactly one result per cycle.
REQ-039 Assert reset with 2 beats in flight -> out_valid=0 at once; no stale result ever emerges; the first post-reset beat emerges after 2 cycles.
